// File: rtl/rgb_led_arbiter.sv
// rtl/rgb_led_arbiter.sv - fixed-priority RGB LED arbiter with minimum hold time and per-channel PWM
// Optional feature: define ARB_PREEMPT_EN to let a higher-priority request cut a hold short.
module rgb_led_arbiter #(
    parameter int PWM_BITS       = 8,
    parameter int PRESCALE       = 16,
    parameter int HOLD_CYCLES    = 10000000,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [2:0]              i_req,
    input  logic [3*PWM_BITS-1:0]   i_colour0,
    input  logic [3*PWM_BITS-1:0]   i_colour1,
    input  logic [3*PWM_BITS-1:0]   i_colour2,
    output logic [2:0]              o_gnt,
    output logic                    o_busy,
    output logic                    o_led_r,
    output logic                    o_led_g,
    output logic                    o_led_b
);

    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, OWN} state_t;

    state_t              state, state_n;
    logic [2:0]          gnt, gnt_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
    logic [3*PWM_BITS-1:0] src_colour;
    logic [2:0]          higher;
    logic                presc_wrap;
    logic                period_end;

    function automatic logic [2:0] lowest(input logic [2:0] r);
        return r & (~r + 3'd1);
    endfunction

    // For a one-hot owner, gnt-1 masks exactly the lower (higher-priority) indices.
    assign higher = i_req & (gnt - 3'd1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            gnt      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            hold_cnt <= hold_n;
        end
    end

    // The OWN decision is also taken on the last HOLD cycle so the hold lasts exactly HOLD_CYCLES.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    gnt_n   = lowest(i_req);
                    hold_n  = HOLD_INIT;
                    state_n = HOLD;
                end
            end
            HOLD, OWN: begin
                if (hold_cnt != '0)
                    hold_n = hold_cnt - 1'b1;
`ifdef ARB_PREEMPT_EN
                if (state == HOLD && |higher) begin
                    gnt_n   = lowest(higher);
                    hold_n  = HOLD_INIT;
                    state_n = HOLD;
                end else
`endif
                if (state == OWN || hold_cnt == '0) begin
                    if ((i_req & gnt) == 3'b000 || |higher) begin
                        if (|i_req) begin
                            gnt_n   = lowest(i_req);
                            hold_n  = HOLD_INIT;
                            state_n = HOLD;
                        end else begin
                            gnt_n   = '0;
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = OWN;
                    end
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        case (gnt)
            3'b001:  src_colour = i_colour0;
            3'b010:  src_colour = i_colour1;
            3'b100:  src_colour = i_colour2;
            default: src_colour = '0;
        endcase
    end

    assign presc_wrap = (presc == PS_LAST);
    assign period_end = presc_wrap && (&pwm_cnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
            duty_r  <= '0;
            duty_g  <= '0;
            duty_b  <= '0;
        end else begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap)
                pwm_cnt <= pwm_cnt + 1'b1;
            // Duties only change at the period boundary to keep each PWM period clean.
            if (period_end) begin
                duty_r <= src_colour[3*PWM_BITS-1:2*PWM_BITS];
                duty_g <= src_colour[2*PWM_BITS-1:PWM_BITS];
                duty_b <= src_colour[PWM_BITS-1:0];
            end
        end
    end

    assign o_gnt   = gnt;
    assign o_busy  = |gnt;
    assign o_led_r = (pwm_cnt < duty_r) ^ LED_ACTIVE_LOW;
    assign o_led_g = (pwm_cnt < duty_g) ^ LED_ACTIVE_LOW;
    assign o_led_b = (pwm_cnt < duty_b) ^ LED_ACTIVE_LOW;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb/tb_rgb_led_arbiter.sv - directed and randomized bench for rgb_led_arbiter (honours ARB_PREEMPT_EN)
module tb_rgb_led_arbiter;

    localparam int PWM_BITS    = 4;
    localparam int PRESCALE    = 1;
    localparam int HOLD_CYCLES = 32;
    localparam int CW          = 3 * PWM_BITS;
    localparam int PERIOD      = 1 << PWM_BITS;
`ifdef ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [2:0]    i_req = 3'b000;
    logic [CW-1:0] i_colour0 = '0;
    logic [CW-1:0] i_colour1 = '0;
    logic [CW-1:0] i_colour2 = '0;
    logic [2:0]    o_gnt;
    logic          o_busy;
    logic          o_led_r, o_led_g, o_led_b;

    always #5 i_clk = ~i_clk;

    rgb_led_arbiter #(
        .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE),
        .HOLD_CYCLES(HOLD_CYCLES), .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
        .i_colour0(i_colour0), .i_colour1(i_colour1), .i_colour2(i_colour2),
        .o_gnt(o_gnt), .o_busy(o_busy),
        .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index (-1 idle), cycles the owner has been shown, PWM phase, duties.
    int m_owner = -1;
    int m_age   = 0;
    int m_pos   = 0;
    int m_duty [3] = '{0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_set(input logic [2:0] r);
        for (int i = 0; i < 3; i++)
            if (r[i]) return i;
        return -1;
    endfunction

    function automatic int chan_duty(input int owner, input int c);
        logic [CW-1:0] col;
        if (owner < 0) return 0;
        col = (owner == 0) ? i_colour0 : (owner == 1) ? i_colour1 : i_colour2;
        return int'((col >> ((2 - c) * PWM_BITS)) & ((1 << PWM_BITS) - 1));
    endfunction

    task automatic model_step();
        int  prev_owner;
        bit  higher;
        bit  may_switch;
        prev_owner = m_owner;
        if (i_rst) begin
            m_owner = -1; m_age = 0; m_pos = 0;
            for (int c = 0; c < 3; c++) m_duty[c] = 0;
        end else begin
            m_pos = (m_pos + 1) % PERIOD;
            if (m_pos == 0)
                for (int c = 0; c < 3; c++) m_duty[c] = chan_duty(prev_owner, c);
            if (m_owner < 0) begin
                if (i_req != 3'b000) begin m_owner = first_set(i_req); m_age = 1; end
            end else begin
                higher     = (int'(i_req) & ((1 << m_owner) - 1)) != 0;
                may_switch = (m_age >= HOLD_CYCLES) || (PREEMPT && higher);
                if (may_switch && (!i_req[m_owner] || higher)) begin
                    m_owner = first_set(i_req);
                    m_age   = (m_owner < 0) ? 0 : 1;
                end else begin
                    m_age++;
                end
            end
        end
    endtask

    function automatic logic [2:0] exp_gnt();
        return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    endfunction

    function automatic logic [2:0] exp_pins();
        logic [2:0] p;
        for (int c = 0; c < 3; c++) p[2 - c] = !(m_pos < m_duty[c]);
        return p;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
        chk("model_gnt", 32'(o_gnt), 32'(exp_gnt()));
        chk("model_busy", 32'(o_busy), 32'(m_owner >= 0));
        chk("model_pins", 32'({o_led_r, o_led_g, o_led_b}), 32'(exp_pins()));
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        i_rst = 1'b0;
    endtask

    initial begin
        int cnt, lo_r, lo_g, lo_b, seg;

        // Reset with every requester active
        i_req = 3'b111;
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_gnt", 32'(o_gnt), 32'd0);
            chk("reset_pins", 32'({o_led_r, o_led_g, o_led_b}), 32'h7);
        end

        // Single request and PWM duty shape
        i_req = 3'b100; i_colour2 = 12'hF80; i_rst = 1'b0;
        do_reset(1);
        tick();
        chk("single_gnt", 32'(o_gnt), 32'h4);
        cnt = 0;
        while (m_pos != PERIOD - 1 && cnt < 40) begin tick(); cnt++; end
        chk("single_align_timeout", 32'(cnt < 40), 32'd1);
        lo_r = 0; lo_g = 0; lo_b = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            lo_r += !o_led_r; lo_g += !o_led_g; lo_b += !o_led_b;
        end
        chk("pwm_r_low", 32'(lo_r), 32'd15);
        chk("pwm_g_low", 32'(lo_g), 32'd8);
        chk("pwm_b_low", 32'(lo_b), 32'd0);

        // Minimum hold after the owner drops its request early
        i_req = 3'b000;
        do_reset(2);
        i_req = 3'b100;
        tick();
        cnt = 1;
        for (int i = 0; i < 4; i++) begin tick(); if (o_gnt == 3'b100) cnt++; end
        i_req = 3'b000;
        for (int i = 0; i < 100 && o_gnt == 3'b100; i++) begin
            tick();
            if (o_gnt == 3'b100) cnt++;
        end
        chk("hold_len", 32'(cnt), 32'd32);
        chk("hold_idle", 32'(o_gnt), 32'd0);
        for (int i = 0; i < PERIOD + 1; i++) tick();
        chk("hold_unlit", 32'({o_led_r, o_led_g, o_led_b}), 32'h7);

        // Simultaneous requests, then higher priority after the hold
        i_colour1 = 12'h3C5; i_colour0 = 12'h1E7;
        do_reset(1);
        i_req = 3'b110;
        tick();
        chk("prio_gnt", 32'(o_gnt), 32'h2);
        for (int i = 0; i < 39; i++) tick();
        i_req = 3'b111;
        tick();
        chk("prio_switch", 32'(o_gnt), 32'h1);

        // Higher-priority request arriving during the hold
        i_req = 3'b000;
        do_reset(1);
        i_req = 3'b100;
        tick();
        for (int k = 2; k <= 10; k++) tick();
        i_req = 3'b101;
        tick();
        chk("preempt_11", 32'(o_gnt), PREEMPT ? 32'h1 : 32'h4);
        for (int k = 12; k <= 33; k++) begin
            tick();
            if (k == 32) chk("preempt_32", 32'(o_gnt), PREEMPT ? 32'h1 : 32'h4);
            if (k == 33) chk("preempt_33", 32'(o_gnt), 32'h1);
        end

        // Reset in the middle of a hold
        i_req = 3'b000;
        do_reset(1);
        i_req = 3'b001; i_colour0 = 12'hFFF;
        for (int i = 0; i < 20; i++) tick();
        i_rst = 1'b1;
        tick();
        chk("midrst_gnt", 32'(o_gnt), 32'd0);
        chk("midrst_pins", 32'({o_led_r, o_led_g, o_led_b}), 32'h7);
        i_rst = 1'b0;
        tick();
        chk("midrst_regrant", 32'(o_gnt), 32'h1);

        // Randomized traffic against the model
        for (int s = 0; s < 60; s++) begin
            i_req     = 3'($urandom_range(0, 7));
            i_colour0 = CW'($urandom);
            i_colour1 = CW'($urandom);
            i_colour2 = CW'($urandom);
            i_rst     = ($urandom_range(0, 29) == 0);
            seg = i_rst ? 1 : $urandom_range(1, 70);
            for (int i = 0; i < seg; i++) tick();
            i_rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
